spi_slave_bus_bridge: RTL and testbench

Downstream stage of the SPI slave controller: converts its control-side stream (address pulse, write beats, read-data requests) into single-beat requests on a req/gnt memory bus. Buffers write beats in a small address-tagged FIFO, prefetches one read word ahead, and auto-increments the address with optional burst wrapping. Single clock domain (`sclk`).

---
 rtl/spi_slave_pkg.sv | 21 ++
 rtl/spi_slave_wr_fifo.sv | 64 ++++++
 rtl/spi_slave_bus_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_spi_slave_bus_bridge.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types for the SPI slave bus bridge: FSM state encoding and the
// write FIFO entry layout at the default address/data widths.
package spi_slave_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } bridge_state_e;

  // Each queued write carries the address captured when the beat arrived.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/spi_slave_wr_fifo.sv
// Synchronous write FIFO for the bus bridge; a pop frees a slot for a push
// in the same cycle, so a full FIFO still accepts a beat while draining.
module spi_slave_wr_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             sclk,
  input  logic             sys_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             empty_next,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  assign empty_next = (count_next == '0);
  assign head       = mem[rd_ptr];

  always_ff @(posedge sclk) begin
    if (sys_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= empty_next;
    end
  end

  always_ff @(posedge sclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_slave_bus_bridge.sv
// Bridges the SPI slave control stream onto a req/gnt memory bus with a write
// FIFO and one-word read prefetch. Define SPI_BRIDGE_WRAP_EN for burst wrapping.
module spi_slave_bus_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  sclk,
  input  logic                  sys_rst,
  input  logic                  cs,
  input  logic                  ctrl_rd_wr,
  input  logic [ADDR_WIDTH-1:0] ctrl_addr,
  input  logic                  ctrl_addr_valid,
  input  logic [DATA_WIDTH-1:0] ctrl_data_rx,
  input  logic                  ctrl_data_rx_valid,
  output logic [DATA_WIDTH-1:0] ctrl_data_tx,
  input  logic                  ctrl_data_tx_ready,
  input  logic [15:0]           wrap_length,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  wr_overflow,
  output logic                  busy
);

  import spi_slave_pkg::*;

  bridge_state_e state;
  bridge_state_e state_next;

  logic [ADDR_WIDTH-1:0] ptr;
  logic                  rd_mode;
  logic                  buf_valid;
  logic                  rd_drop;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_empty_next;
  logic                  fifo_pop;
  logic                  wr_accept;
  logic                  rd_capture;
  logic                  advance;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign fifo_pop   = (state == WR_REQ) && bus_gnt;
  assign wr_accept  = ctrl_data_rx_valid && (!fifo_full || fifo_pop);
  assign rd_capture = (state == RD_WAIT) && bus_rvalid && !rd_drop && !cs && !ctrl_addr_valid;
  assign advance    = wr_accept || rd_capture;
  assign {head_addr, head_data} = fifo_head;

  spi_slave_wr_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .sclk       (sclk),
    .sys_rst    (sys_rst),
    .push       (wr_accept),
    .din        ({ptr, ctrl_data_rx}),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next),
    .head       (fifo_head)
  );

`ifdef SPI_BRIDGE_WRAP_EN
  logic [ADDR_WIDTH-1:0] base;
  logic [15:0]           beat;
  logic                  wrap_hit;

  assign wrap_hit = (wrap_length != 16'd0) && (16'(beat + 16'd1) == wrap_length);

  always_ff @(posedge sclk) begin
    if (sys_rst) begin
      ptr  <= '0;
      base <= '0;
      beat <= '0;
    end else if (ctrl_addr_valid) begin
      ptr  <= ctrl_addr;
      base <= ctrl_addr;
      beat <= '0;
    end else if (advance) begin
      if (wrap_hit) begin
        ptr  <= base;
        beat <= '0;
      end else begin
        ptr  <= ptr + ADDR_WIDTH'(1);
        beat <= beat + 16'd1;
      end
    end
  end
`else
  logic unused_wrap_length;
  assign unused_wrap_length = ^wrap_length;

  always_ff @(posedge sclk) begin
    if (sys_rst) begin
      ptr <= '0;
    end else if (ctrl_addr_valid) begin
      ptr <= ctrl_addr;
    end else if (advance) begin
      ptr <= ptr + ADDR_WIDTH'(1);
    end
  end
`endif

  // Reads never start while a new access or write beat could still move ptr.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = WR_REQ;
        end else if (rd_mode && !buf_valid && !cs && !ctrl_addr_valid && !ctrl_data_rx_valid) begin
          state_next = RD_REQ;
        end
      end
      WR_REQ: begin
        if (bus_gnt) state_next = IDLE;
      end
      RD_REQ: begin
        if (bus_gnt) begin
          state_next = RD_WAIT;
        end else if (cs || ctrl_addr_valid) begin
          state_next = IDLE;
        end
      end
      RD_WAIT: begin
        if (bus_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A read already granted must still absorb its response; rd_drop marks it stale.
  always_ff @(posedge sclk) begin
    if (sys_rst) begin
      state   <= IDLE;
      rd_drop <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        rd_drop <= 1'b0;
      end else if (((state == RD_REQ) && bus_gnt) || (state == RD_WAIT)) begin
        if (cs || ctrl_addr_valid) rd_drop <= 1'b1;
      end
    end
  end

  // Request fields latch on entry to a request state and hold until grant.
  always_ff @(posedge sclk) begin
    if (sys_rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      bus_req <= (state_next == WR_REQ) || (state_next == RD_REQ);
      busy    <= !fifo_empty_next || (state_next != IDLE);
      if ((state == IDLE) && (state_next == WR_REQ)) begin
        bus_we    <= 1'b1;
        bus_addr  <= head_addr;
        bus_wdata <= head_data;
      end else if ((state == IDLE) && (state_next == RD_REQ)) begin
        bus_we   <= 1'b0;
        bus_addr <= ptr;
      end
    end
  end

  // Invalidating the buffer leaves its last data visible on ctrl_data_tx.
  always_ff @(posedge sclk) begin
    if (sys_rst) begin
      rd_mode      <= 1'b0;
      buf_valid    <= 1'b0;
      ctrl_data_tx <= '0;
      wr_overflow  <= 1'b0;
    end else begin
      if (cs) begin
        rd_mode <= 1'b0;
      end else if (ctrl_addr_valid) begin
        rd_mode <= ctrl_rd_wr;
      end

      if (ctrl_addr_valid || cs) begin
        buf_valid <= 1'b0;
      end else if (rd_capture) begin
        buf_valid    <= 1'b1;
        ctrl_data_tx <= bus_rdata;
      end else if (ctrl_data_tx_ready && buf_valid) begin
        buf_valid <= 1'b0;
      end

      if (ctrl_addr_valid) begin
        wr_overflow <= 1'b0;
      end else if (ctrl_data_rx_valid && !wr_accept) begin
        wr_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_bus_bridge.sv
// Directed self-checking bench for spi_slave_bus_bridge; the wrap scenario
// runs only when SPI_BRIDGE_WRAP_EN is defined.
module tb_spi_slave_bus_bridge;

  logic        sclk = 1'b0;
  logic        sys_rst;
  logic        cs;
  logic        ctrl_rd_wr;
  logic [11:0] ctrl_addr;
  logic        ctrl_addr_valid;
  logic [7:0]  ctrl_data_rx;
  logic        ctrl_data_rx_valid;
  logic [7:0]  ctrl_data_tx;
  logic        ctrl_data_tx_ready;
  logic [15:0] wrap_length;
  logic        bus_req;
  logic        bus_we;
  logic [11:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [7:0]  bus_rdata;
  logic        wr_overflow;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic        gnt_hold = 1'b0;
  logic [20:0] wr_log [$];

  spi_slave_bus_bridge dut (
    .sclk               (sclk),
    .sys_rst            (sys_rst),
    .cs                 (cs),
    .ctrl_rd_wr         (ctrl_rd_wr),
    .ctrl_addr          (ctrl_addr),
    .ctrl_addr_valid    (ctrl_addr_valid),
    .ctrl_data_rx       (ctrl_data_rx),
    .ctrl_data_rx_valid (ctrl_data_rx_valid),
    .ctrl_data_tx       (ctrl_data_tx),
    .ctrl_data_tx_ready (ctrl_data_tx_ready),
    .wrap_length        (wrap_length),
    .bus_req            (bus_req),
    .bus_we             (bus_we),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_gnt            (bus_gnt),
    .bus_rvalid         (bus_rvalid),
    .bus_rdata          (bus_rdata),
    .wr_overflow        (wr_overflow),
    .busy               (busy)
  );

  always #5 sclk = ~sclk;

  // Records every granted request as {we, addr, wdata}.
  always @(negedge sclk) begin
    #1;
    if (bus_req && bus_gnt) wr_log.push_back({bus_we, bus_addr, bus_wdata});
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sclk);
  endtask

  task automatic apply_addr(input logic [11:0] addr, input logic rd);
    ctrl_addr       = addr;
    ctrl_rd_wr      = rd;
    ctrl_addr_valid = 1'b1;
    tick();
    ctrl_addr_valid = 1'b0;
  endtask

  task automatic apply_beat(input logic [7:0] data);
    ctrl_data_rx       = data;
    ctrl_data_rx_valid = 1'b1;
    tick();
    ctrl_data_rx_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!bus_req && n < 30) begin
      tick();
      n++;
    end
    check_output(tag, 32'(bus_req), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check_output(tag, 32'(busy), 32'd0);
  endtask

  task automatic grant();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = gnt_hold;
  endtask

  task automatic respond(input logic [7:0] data);
    bus_rdata  = data;
    bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
  endtask

  task automatic serve_write(input string tag, input logic [11:0] addr, input logic [7:0] data);
    wait_req(tag);
    check_output({tag, "_we"},   32'(bus_we),    32'd1);
    check_output({tag, "_addr"}, 32'(bus_addr),  32'(addr));
    check_output({tag, "_data"}, 32'(bus_wdata), 32'(data));
    grant();
  endtask

  task automatic serve_read(input string tag, input logic [11:0] addr, input logic [7:0] data);
    wait_req(tag);
    check_output({tag, "_we"},   32'(bus_we),   32'd0);
    check_output({tag, "_addr"}, 32'(bus_addr), 32'(addr));
    grant();
    respond(data);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_req"},   32'(bus_req),      32'd0);
    check_output({tag, "_we"},    32'(bus_we),       32'd0);
    check_output({tag, "_addr"},  32'(bus_addr),     32'd0);
    check_output({tag, "_wdata"}, 32'(bus_wdata),    32'd0);
    check_output({tag, "_tx"},    32'(ctrl_data_tx), 32'd0);
    check_output({tag, "_ovf"},   32'(wr_overflow),  32'd0);
    check_output({tag, "_busy"},  32'(busy),         32'd0);
  endtask

  initial begin
    logic [7:0]  t1_data [3];
    logic [11:0] wrap_addr [6];
    logic [20:0] entry;
    int          seen;

    t1_data   = '{8'hA1, 8'hA2, 8'hA3};
    wrap_addr = '{12'h020, 12'h021, 12'h022, 12'h023, 12'h020, 12'h021};

    sys_rst            = 1'b1;
    cs                 = 1'b1;
    ctrl_rd_wr         = 1'b0;
    ctrl_addr          = '0;
    ctrl_addr_valid    = 1'b0;
    ctrl_data_rx       = '0;
    ctrl_data_rx_valid = 1'b0;
    ctrl_data_tx_ready = 1'b0;
    wrap_length        = 16'd0;
    bus_gnt            = 1'b0;
    bus_rvalid         = 1'b0;
    bus_rdata          = '0;
    repeat (3) tick();
    check_all_zero("reset");
    sys_rst = 1'b0;
    cs      = 1'b0;
    tick();

    $display("[TB] write burst with grant tied high");
    wr_log.delete();
    gnt_hold = 1'b1;
    bus_gnt  = 1'b1;
    apply_addr(12'h010, 1'b0);
    apply_beat(8'hA1);
    apply_beat(8'hA2);
    apply_beat(8'hA3);
    wait_idle("t1_idle");
    check_output("t1_count", 32'(wr_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      entry = (i < wr_log.size()) ? wr_log[i] : 21'h0;
      check_output("t1_beat", 32'(entry), 32'({1'b1, 12'h010 + 12'(i), t1_data[i]}));
    end
    gnt_hold = 1'b0;
    bus_gnt  = 1'b0;

    $display("[TB] read prefetch across 0x0FF");
    apply_addr(12'h0FF, 1'b1);
    serve_read("t2_rd0", 12'h0FF, 8'h55);
    check_output("t2_tx0", 32'(ctrl_data_tx), 32'h55);
    repeat (3) tick();
    check_output("t2_hold", 32'(bus_req), 32'd0);
    ctrl_data_tx_ready = 1'b1;
    tick();
    ctrl_data_tx_ready = 1'b0;
    serve_read("t2_rd1", 12'h100, 8'h66);
    check_output("t2_tx1", 32'(ctrl_data_tx), 32'h66);
    cs = 1'b1;
    repeat (2) tick();
    cs = 1'b0;

    $display("[TB] overflow with grant held low");
    apply_addr(12'h030, 1'b0);
    for (int i = 0; i < 5; i++) apply_beat(8'hD0 + 8'(i));
    check_output("t3_ovf_set", 32'(wr_overflow), 32'd1);
    check_output("t3_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) serve_write("t3_wr", 12'h030 + 12'(i), 8'hD0 + 8'(i));
    apply_beat(8'hE0);
    serve_write("t3_next", 12'h034, 8'hE0);
    check_output("t3_ovf_sticky", 32'(wr_overflow), 32'd1);
    apply_addr(12'h040, 1'b0);
    check_output("t3_ovf_clr", 32'(wr_overflow), 32'd0);

    $display("[TB] queued writes ahead of read");
    apply_addr(12'h050, 1'b0);
    apply_beat(8'hB0);
    apply_beat(8'hB1);
    apply_addr(12'h060, 1'b1);
    serve_write("t4_wr0", 12'h050, 8'hB0);
    serve_write("t4_wr1", 12'h051, 8'hB1);
    serve_read("t4_rd", 12'h060, 8'h77);
    check_output("t4_tx", 32'(ctrl_data_tx), 32'h77);
    cs = 1'b1;
    tick();
    cs = 1'b0;

    $display("[TB] chip select abort during read wait");
    apply_addr(12'h070, 1'b1);
    wait_req("t5_req");
    check_output("t5_addr", 32'(bus_addr), 32'h070);
    grant();
    cs = 1'b1;
    tick();
    respond(8'h99);
    tick();
    cs   = 1'b0;
    seen = 0;
    repeat (8) begin
      tick();
      if (bus_req) seen++;
    end
    check_output("t5_no_req", 32'(seen), 32'd0);
    check_output("t5_tx", 32'(ctrl_data_tx), 32'h77);

    $display("[TB] reset mid burst");
    apply_addr(12'h0A0, 1'b0);
    for (int i = 0; i < 5; i++) apply_beat(8'h10 + 8'(i));
    check_output("t6_pre_req", 32'(bus_req), 32'd1);
    check_output("t6_pre_ovf", 32'(wr_overflow), 32'd1);
    sys_rst = 1'b1;
    tick();
    check_all_zero("t6_rst");
    sys_rst = 1'b0;
    repeat (5) tick();
    check_output("t6_post_req", 32'(bus_req), 32'd0);
    check_output("t6_post_busy", 32'(busy), 32'd0);

`ifdef SPI_BRIDGE_WRAP_EN
    $display("[TB] wrap length 4");
    wr_log.delete();
    wrap_length = 16'd4;
    gnt_hold    = 1'b1;
    bus_gnt     = 1'b1;
    apply_addr(12'h020, 1'b0);
    for (int i = 0; i < 6; i++) apply_beat(8'h30 + 8'(i));
    wait_idle("t7_idle");
    check_output("t7_count", 32'(wr_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      entry = (i < wr_log.size()) ? wr_log[i] : 21'h0;
      check_output("t7_beat", 32'(entry), 32'({1'b1, wrap_addr[i], 8'h30 + 8'(i)}));
    end
    gnt_hold = 1'b0;
    bus_gnt  = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
